// File: rtl/ann_layer_sequencer_if.sv
// Handshake, configuration and shared-neuron bus of the ANN layer sequencer.
// The slave side is the sequencer; the master side is the wrapper plus neuron datapath.
interface ann_layer_sequencer_if #(parameter int DW = 4);
  logic            start_i;
  logic [DW-1:0]   in1_i;
  logic [DW-1:0]   in2_i;
  logic            cfg_we_i;
  logic [1:0]      cfg_addr_i;
  logic [3*DW-1:0] cfg_data_i;
  logic            busy_o;
  logic            done_o;
  logic [DW-1:0]   out_o;
  logic            cfg_err_o;
  logic            n_go_o;
  logic [DW-1:0]   n_in1_o;
  logic [DW-1:0]   n_in2_o;
  logic [DW-1:0]   n_w1_o;
  logic [DW-1:0]   n_w2_o;
  logic [DW-1:0]   n_t_o;
  logic [DW-1:0]   n_out_i;

  modport slave (
    input  start_i, in1_i, in2_i, cfg_we_i, cfg_addr_i, cfg_data_i, n_out_i,
    output busy_o, done_o, out_o, cfg_err_o,
           n_go_o, n_in1_o, n_in2_o, n_w1_o, n_w2_o, n_t_o
  );

  modport master (
    output start_i, in1_i, in2_i, cfg_we_i, cfg_addr_i, cfg_data_i, n_out_i,
    input  busy_o, done_o, out_o, cfg_err_o,
           n_go_o, n_in1_o, n_in2_o, n_w1_o, n_w2_o, n_t_o
  );
endinterface

// File: rtl/ann_layer_sequencer.sv
// Time-multiplexes one shared neuron over a 2-2-1 network (H0, H1, then O),
// holding the per-neuron {w1,w2,t} bank and sequencing issue, wait and capture.
module ann_layer_sequencer #(
  parameter int NEU_LAT = 1,
  parameter int DW      = 4
) (
  input logic                   clk,
  input logic                   rst,
  ann_layer_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

  localparam logic [2:0] LatInit = 3'(NEU_LAT);

  state_e          state_q, state_d;
  logic [1:0]      step_q, step_d;
  logic [2:0]      waitCnt_q, waitCnt_d;
  logic [3*DW-1:0] bank_q [3];
  logic [DW-1:0]   in1Lat_q, in2Lat_q, h0_q, out_q;
  logic [DW-1:0]   nIn1_q, nIn2_q, nW1_q, nW2_q, nT_q;
  logic            cfgErr_q;

  logic            accept, cfgOk, lastWait, loadOps;
  logic [3*DW-1:0] nextEntry;
  logic [DW-1:0]   opA, opB;

  assign accept   = (state_q == IDLE) && bus.start_i;
  assign cfgOk    = bus.cfg_we_i && (state_q == IDLE) && (bus.cfg_addr_i != 2'd3);
  assign lastWait = (state_q == WAIT) && (waitCnt_q == 3'd1);
  assign loadOps  = accept || (lastWait && (step_q != 2'd2));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      step_q    <= '0;
      waitCnt_q <= '0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      waitCnt_q <= waitCnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    waitCnt_d = waitCnt_q;
    case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          state_d = ISSUE;
          step_d  = 2'd0;
        end
      end
      ISSUE: begin
        state_d   = WAIT;
        waitCnt_d = LatInit;
      end
      WAIT: begin
        waitCnt_d = waitCnt_q - 3'd1;
        if (waitCnt_q == 3'd1) begin
          if (step_q == 2'd2) begin
            state_d = DONE;
          end else begin
            state_d = ISSUE;
            step_d  = step_q + 2'd1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.busy_o = (state_q != IDLE);
    bus.done_o = (state_q == DONE);
    bus.n_go_o = (state_q == ISSUE);
  end

  // Operands for the step about to issue; a same-edge write to entry 0 is forwarded,
  // and H1's result goes straight into operand 2 so no separate h1 register is kept.
  always_comb begin
    nextEntry = bank_q[0];
    opA       = bus.in1_i;
    opB       = bus.in2_i;
    if (accept) begin
      if (cfgOk && (bus.cfg_addr_i == 2'd0)) nextEntry = bus.cfg_data_i;
    end else if (step_q == 2'd0) begin
      nextEntry = bank_q[1];
      opA       = in1Lat_q;
      opB       = in2Lat_q;
    end else begin
      nextEntry = bank_q[2];
      opA       = h0_q;
      opB       = bus.n_out_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) bank_q[i] <= '0;
      cfgErr_q <= 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (cfgOk && (bus.cfg_addr_i == 2'(i))) bank_q[i] <= bus.cfg_data_i;
      end
      cfgErr_q <= bus.cfg_we_i && !cfgOk;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in1Lat_q <= '0;
      in2Lat_q <= '0;
      h0_q     <= '0;
      out_q    <= '0;
      nIn1_q   <= '0;
      nIn2_q   <= '0;
      nW1_q    <= '0;
      nW2_q    <= '0;
      nT_q     <= '0;
    end else begin
      if (accept) begin
        in1Lat_q <= bus.in1_i;
        in2Lat_q <= bus.in2_i;
      end
      if (lastWait && (step_q == 2'd0)) h0_q  <= bus.n_out_i;
      if (lastWait && (step_q == 2'd2)) out_q <= bus.n_out_i;
      if (loadOps) begin
        nIn1_q <= opA;
        nIn2_q <= opB;
        nW1_q  <= nextEntry[3*DW-1:2*DW];
        nW2_q  <= nextEntry[2*DW-1:DW];
        nT_q   <= nextEntry[DW-1:0];
      end
    end
  end

  assign bus.out_o     = out_q;
  assign bus.cfg_err_o = cfgErr_q;
  assign bus.n_in1_o   = nIn1_q;
  assign bus.n_in2_o   = nIn2_q;
  assign bus.n_w1_o    = nW1_q;
  assign bus.n_w2_o    = nW2_q;
  assign bus.n_t_o     = nT_q;

endmodule

// File: tb/tb_ann_layer_sequencer.sv
// Bench for ann_layer_sequencer: two instances (NEU_LAT=1 and 3), each with a
// behavioural neuron, checked against a network-level reference model.
module tb_ann_layer_sequencer;

  localparam int DW    = 4;
  localparam int LAT_A = 1;
  localparam int LAT_B = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ann_layer_sequencer_if #(.DW(DW)) ifA ();
  ann_layer_sequencer_if #(.DW(DW)) ifB ();

  ann_layer_sequencer #(.NEU_LAT(LAT_A), .DW(DW)) dutA (.clk(clk), .rst(rst), .bus(ifA));
  ann_layer_sequencer #(.NEU_LAT(LAT_B), .DW(DW)) dutB (.clk(clk), .rst(rst), .bus(ifB));

  int          sel = 0;
  logic        start = 1'b0;
  logic        cfgWe = 1'b0;
  logic [3:0]  in1 = '0;
  logic [3:0]  in2 = '0;
  logic [1:0]  cfgAddr = '0;
  logic [11:0] cfgData = '0;

  int compared   = 0;
  int mismatched = 0;

  logic [11:0] refBank [2][3];

  // Threshold neuron: all ones when the weighted sum reaches the threshold.
  function automatic logic [3:0] neuron(input logic [3:0] i1, input logic [3:0] i2,
                                        input logic [11:0] e);
    int s;
    s = int'(i1) * int'(e[11:8]) + int'(i2) * int'(e[7:4]);
    return (s >= int'(e[3:0])) ? 4'hF : 4'h0;
  endfunction

  assign ifA.start_i    = start & (sel == 0);
  assign ifA.cfg_we_i   = cfgWe & (sel == 0);
  assign ifA.in1_i      = in1;
  assign ifA.in2_i      = in2;
  assign ifA.cfg_addr_i = cfgAddr;
  assign ifA.cfg_data_i = cfgData;
  assign ifB.start_i    = start & (sel == 1);
  assign ifB.cfg_we_i   = cfgWe & (sel == 1);
  assign ifB.in1_i      = in1;
  assign ifB.in2_i      = in2;
  assign ifB.cfg_addr_i = cfgAddr;
  assign ifB.cfg_data_i = cfgData;

  // The neuron result is only correct in the single cycle NEU_LAT after n_go;
  // otherwise it shows the inverted value so a mistimed capture is visible.
  logic [3:0] pendA, pendB;
  int         cntA, cntB;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pendA <= '0;
      cntA  <= 0;
    end else if (ifA.n_go_o) begin
      pendA <= neuron(ifA.n_in1_o, ifA.n_in2_o, {ifA.n_w1_o, ifA.n_w2_o, ifA.n_t_o});
      cntA  <= LAT_A;
    end else if (cntA > 0) begin
      cntA <= cntA - 1;
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pendB <= '0;
      cntB  <= 0;
    end else if (ifB.n_go_o) begin
      pendB <= neuron(ifB.n_in1_o, ifB.n_in2_o, {ifB.n_w1_o, ifB.n_w2_o, ifB.n_t_o});
      cntB  <= LAT_B;
    end else if (cntB > 0) begin
      cntB <= cntB - 1;
    end
  end

  assign ifA.n_out_i = (cntA == 1) ? pendA : ~pendA;
  assign ifB.n_out_i = (cntB == 1) ? pendB : ~pendB;

  logic        obsBusy, obsDone, obsGo, obsErr;
  logic [3:0]  obsOut;
  logic [19:0] obsOps;

  always_comb begin
    if (sel == 0) begin
      obsBusy = ifA.busy_o;
      obsDone = ifA.done_o;
      obsGo   = ifA.n_go_o;
      obsErr  = ifA.cfg_err_o;
      obsOut  = ifA.out_o;
      obsOps  = {ifA.n_in1_o, ifA.n_in2_o, ifA.n_w1_o, ifA.n_w2_o, ifA.n_t_o};
    end else begin
      obsBusy = ifB.busy_o;
      obsDone = ifB.done_o;
      obsGo   = ifB.n_go_o;
      obsErr  = ifB.cfg_err_o;
      obsOut  = ifB.out_o;
      obsOps  = {ifB.n_in1_o, ifB.n_in2_o, ifB.n_w1_o, ifB.n_w2_o, ifB.n_t_o};
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic selectDut(input int s);
    sel = s;
    #1;
  endtask

  task automatic writeCfg(input logic [1:0] addr, input logic [11:0] data);
    cfgWe   = 1'b1;
    cfgAddr = addr;
    cfgData = data;
    tick();
    cfgWe = 1'b0;
    checkOutput($sformatf("L%0d cfg_err addr%0d", sel, addr), obsErr, (addr == 2'd3));
    if (addr != 2'd3) refBank[sel][addr] = data;
    tick();
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, " busy"}, obsBusy, 0);
    checkOutput({tag, " done"}, obsDone, 0);
    checkOutput({tag, " n_go"}, obsGo, 0);
    checkOutput({tag, " cfg_err"}, obsErr, 0);
    checkOutput({tag, " out"}, obsOut, 0);
    checkOutput({tag, " ops"}, obsOps, 0);
  endtask

  // One full evaluation, optionally disturbed by a second start and an in1 change,
  // a write while busy, or a bank-0 write on the accepting edge.
  task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b, input bit disturb,
                               input bit busyWrite, input bit sameEdge, input logic [11:0] sameData);
    int          lat, n;
    logic [3:0]  h0, h1, res;
    logic [19:0] expOps [3];
    string       dn;
    lat = (sel == 0) ? LAT_A : LAT_B;
    n   = 3 * (lat + 1);
    dn  = (sel == 0) ? "L1" : "L3";
    if (sameEdge) begin
      cfgWe   = 1'b1;
      cfgAddr = 2'd0;
      cfgData = sameData;
      refBank[sel][0] = sameData;
    end
    h0  = neuron(a, b, refBank[sel][0]);
    h1  = neuron(a, b, refBank[sel][1]);
    res = neuron(h0, h1, refBank[sel][2]);
    expOps[0] = {a, b, refBank[sel][0]};
    expOps[1] = {a, b, refBank[sel][1]};
    expOps[2] = {h0, h1, refBank[sel][2]};
    start = 1'b1;
    in1   = a;
    in2   = b;
    tick();
    start = 1'b0;
    cfgWe = 1'b0;
    for (int c = 0; c <= n + 1; c++) begin
      checkOutput($sformatf("%s c%0d n_go", dn, c), obsGo, (c < n) && (c % (lat + 1) == 0));
      checkOutput($sformatf("%s c%0d busy", dn, c), obsBusy, (c <= n));
      checkOutput($sformatf("%s c%0d done", dn, c), obsDone, (c == n));
      checkOutput($sformatf("%s c%0d cfg_err", dn, c), obsErr, busyWrite && (c == 3));
      if (c < n) checkOutput($sformatf("%s c%0d ops", dn, c), obsOps, expOps[c / (lat + 1)]);
      if (c >= n) checkOutput($sformatf("%s c%0d out", dn, c), obsOut, res);
      if (disturb && c == 1) begin
        start = 1'b1;
        in1   = 4'd7;
      end
      if (disturb && c == 2) start = 1'b0;
      if (busyWrite && c == 2) begin
        cfgWe   = 1'b1;
        cfgAddr = 2'd1;
        cfgData = 12'($urandom);
      end
      if (busyWrite && c == 3) cfgWe = 1'b0;
      tick();
    end
  endtask

  task automatic resetMidRun();
    bit sawDone;
    start = 1'b1;
    in1   = 4'd1;
    in2   = 4'd1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    checkOutput("midrun busy_before", obsBusy, 1);
    #1 rst = 1'b1;
    #1;
    checkOutput("midrun busy", obsBusy, 0);
    checkOutput("midrun n_go", obsGo, 0);
    checkOutput("midrun out", obsOut, 0);
    checkOutput("midrun done", obsDone, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int d = 0; d < 2; d++) for (int e = 0; e < 3; e++) refBank[d][e] = '0;
    sawDone = 1'b0;
    repeat (10) begin
      tick();
      if (obsDone) sawDone = 1'b1;
    end
    checkOutput("midrun no_done", sawDone, 0);
  endtask

  task automatic loadBasicBank();
    writeCfg(2'd0, {4'd2, 4'd3, 4'd5});
    writeCfg(2'd1, {4'd1, 4'd1, 4'd9});
    writeCfg(2'd2, {4'd4, 4'd4, 4'd8});
  endtask

  initial begin
    $display("[TB] ann_layer_sequencer bench starting");
    for (int d = 0; d < 2; d++) for (int e = 0; e < 3; e++) refBank[d][e] = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    selectDut(0);
    checkReset("L1 in_reset");
    selectDut(1);
    checkReset("L3 in_reset");
    @(negedge clk);
    rst = 1'b0;
    tick();
    selectDut(0);
    checkReset("L1 after_reset");
    tick();

    loadBasicBank();
    applyStimulus(4'd1, 4'd1, 1'b0, 1'b0, 1'b0, '0);
    applyStimulus(4'd1, 4'd1, 1'b1, 1'b1, 1'b0, '0);
    writeCfg(2'd3, 12'hABC);
    applyStimulus(4'd1, 4'd1, 1'b0, 1'b0, 1'b0, '0);
    applyStimulus(4'd1, 4'd1, 1'b0, 1'b0, 1'b1, {4'd1, 4'd1, 4'd2});
    for (int r = 0; r < 6; r++) begin
      for (int e = 0; e < 3; e++) writeCfg(2'(e), 12'($urandom));
      applyStimulus(4'($urandom), 4'($urandom), 1'b0, 1'b0, 1'b0, '0);
    end

    loadBasicBank();
    applyStimulus(4'd1, 4'd1, 1'b0, 1'b0, 1'b0, '0);
    resetMidRun();
    applyStimulus(4'd1, 4'd1, 1'b0, 1'b0, 1'b0, '0);

    selectDut(1);
    @(negedge clk);
    loadBasicBank();
    applyStimulus(4'd1, 4'd1, 1'b0, 1'b0, 1'b0, '0);
    applyStimulus(4'd1, 4'd1, 1'b1, 1'b1, 1'b0, '0);
    for (int r = 0; r < 4; r++) begin
      for (int e = 0; e < 3; e++) writeCfg(2'(e), 12'($urandom));
      applyStimulus(4'($urandom), 4'($urandom), 1'b0, 1'b0, 1'b0, '0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
